// File: rtl/uart_tx_16x.sv
// uart_tx_16x: ready/valid UART transmitter timed by an external OVERSAMPLE x baud tick enable.
// Frame: start, DATA_BITS LSB first, optional odd/even parity, STOP_BITS stop bits.
module uart_tx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk50MHz,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int TW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q;
    logic [TW-1:0]          tick_q;
    logic [TW-1:0]          tick_d;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   tick_end;

    assign tick_end = baud_tick && (tick_q == TW'(OVERSAMPLE - 1));
    assign tick_d   = tick_end ? '0 : tick_q + 1'b1;

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state_q == S_IDLE) begin
                if (tx_valid) begin
                    shift_q  <= tx_data;
                    par_q    <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                    tick_q   <= '0;
                    bit_q    <= '0;
                    state_q  <= S_START;
                    tx       <= 1'b0;
                    tx_ready <= 1'b0;
                    tx_busy  <= 1'b1;
                end
            end else begin
                if (baud_tick)
                    tick_q <= tick_d;
                // every state change and tx update happens on the last tick of a bit period
                if (tick_end) begin
                    case (state_q)
                        S_START: begin
                            state_q <= S_DATA;
                            tx      <= shift_q[0];
                        end
                        S_DATA: begin
                            shift_q <= shift_q >> 1;
                            if (bit_q == BW'(DATA_BITS - 1)) begin
                                bit_q   <= '0;
                                state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                                tx      <= (PARITY != 0) ? par_q : 1'b1;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                                tx    <= shift_q[1];
                            end
                        end
                        S_PARITY: begin
                            state_q <= S_STOP;
                            tx      <= 1'b1;
                        end
                        S_STOP: begin
                            if (bit_q == BW'(STOP_BITS - 1)) begin
                                bit_q    <= '0;
                                state_q  <= S_IDLE;
                                tx_ready <= 1'b1;
                                tx_busy  <= 1'b0;
                                tx_done  <= 1'b1;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
